// File: rtl/fullyconn_nxm_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fullyconn_nxm_pipe                                             |
// | Purpose  : N-input / M-output switch cell for the CGRA interconnect.      |
// |            Each output selects one input and is presented either         |
// |            combinationally or through a one-cycle pipeline register.     |
// |            Configuration arrives on a serial chain into a shadow         |
// |            register and is committed to the active config atomically.    |
// | Ports    : config_clk   - sole clock, rising edge                         |
// |            config_reset - asynchronous active-low reset                   |
// |            config_in    - serial config bit (LSB of bitstream first)      |
// |            config_en    - shift enable for the shadow chain               |
// |            config_load  - commit shadow to active config                  |
// |            config_out   - serial chain output (shadow[0])                 |
// |            in           - N words, input i at [i*size +: size]            |
// |            out          - M words, output j at [j*size +: size]           |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module fullyconn_nxm_pipe #(
  parameter int size = 32,
  parameter int N    = 4,
  parameter int M    = 1
) (
  input  logic                config_clk,
  input  logic                config_reset,
  input  logic                config_in,
  input  logic                config_en,
  input  logic                config_load,
  output logic                config_out,
  input  logic [N*size-1:0]   in,
  output logic [M*size-1:0]   out
);

  localparam int SELW = $clog2(N);
  localparam int FW   = SELW + 1;
  localparam int CFGW = M * FW;

  logic [CFGW-1:0] r_shadow;
  logic [CFGW-1:0] r_active;

  // Shadow chain shifts toward bit 0, so the first bit shifted in ends at
  // shadow[0] after CFGW shifts and is also what config_out presents.
  always_ff @(posedge config_clk or negedge config_reset) begin
    if (!config_reset) begin
      r_shadow <= '0;
    end else if (config_en) begin
      r_shadow <= {config_in, r_shadow[CFGW-1:1]};
    end
  end

  // Commit samples the pre-edge shadow, so a same-edge shift never leaks
  // a half-shifted value into the datapath.
  always_ff @(posedge config_clk or negedge config_reset) begin
    if (!config_reset) begin
      r_active <= '0;
    end else if (config_load) begin
      r_active <= r_shadow;
    end
  end

  assign config_out = r_shadow[0];

  generate
    for (genvar j = 0; j < M; j++) begin : g_out
      logic [SELW-1:0] w_sel;
      logic            w_reg;
      logic [size-1:0] w_mux;
      logic [size-1:0] r_pipe;

      assign w_sel = r_active[j*FW +: SELW];
      assign w_reg = r_active[j*FW + SELW];

      // Select by equality scan: codes at or above N match nothing and
      // leave the default of zero, covering non-power-of-two N.
      always_comb begin
        w_mux = '0;
        for (int i = 0; i < N; i++) begin
          if (w_sel == SELW'(i)) begin
            w_mux = in[i*size +: size];
          end
        end
      end

      // Captured every edge regardless of mode, so switching an output to
      // registered mode presents the previous cycle's selection at once.
      always_ff @(posedge config_clk or negedge config_reset) begin
        if (!config_reset) begin
          r_pipe <= '0;
        end else begin
          r_pipe <= w_mux;
        end
      end

      assign out[j*size +: size] = w_reg ? r_pipe : w_mux;
    end
  endgenerate

endmodule
`default_nettype wire
